// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes seen by the decoder
// and the unit's FSM state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_md_op(input logic [3:0] code);
    return (code == OP_MULT) || (code == OP_MULTU) ||
           (code == OP_DIV)  || (code == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Results are computed from latched operands and committed when the count expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_p0, b_p0;
  mdu_op_e          op_p0;
  logic             accept, finish;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] div_s, div_u;

  // Sign/magnitude division: quotient truncates toward zero, remainder takes
  // the dividend's sign. A zero divisor yields 0 here; the caller skips the write.
  function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic [31:0] ua, ub, uq, ur;
    logic        neg_q, neg_r;
    neg_r = sgn & a[31];
    neg_q = sgn & (a[31] ^ b[31]);
    ua = neg_r ? -a : a;
    ub = (sgn & b[31]) ? -b : b;
    if (ub == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    uq = neg_q ? -uq : uq;
    ur = neg_r ? -ur : ur;
    return {ur, uq};
  endfunction

  assign a_sx   = {{32{a_p0[31]}}, a_p0};
  assign b_sx   = {{32{b_p0[31]}}, b_p0};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_p0} * {32'd0, b_p0};
  assign div_s  = div_result(a_p0, b_p0, 1'b1);
  assign div_u  = div_result(a_p0, b_p0, 1'b0);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel && is_md_op(op)) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      op_p0   <= OP_NONE;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      // Operand latch stage: inputs are ignored until the running op commits.
      if (accept) begin
        a_p0  <= inA;
        b_p0  <= inB;
        op_p0 <= mdu_op_e'(op);
        cnt_q <= (op == OP_MULT || op == OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Commit stage
      if (finish) begin
        case (op_p0)
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          OP_DIV:   if (b_p0 != 32'd0) {hi, lo} <= div_s;
          OP_DIVU:  if (b_p0 != 32'd0) {hi, lo} <= div_u;
          default: ;
        endcase
      end else if (state_q == ST_IDLE && !cancel) begin
        if (op == OP_MTHI) hi <= inA;
        if (op == OP_MTLO) lo <= inA;
      end
    end
  end

  assign busy = (state_q == ST_BUSY);

  always_comb begin
    out = 32'd0;
    if (op == OP_MFHI) out = hi;
    else if (op == OP_MFLO) out = lo;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO results.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] inA, inB;
  logic        busy;
  logic [31:0] hi, lo, out;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, settle, and count cycles with busy high.
  task automatic step();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = OP_NONE; cancel = 1'b0; inA = 32'd0; inB = 32'd0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      step();
      guard++;
    end
    if (busy) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    busy_cnt = 0;
    start = 1'b1; op = code; inA = a; inB = b;
    step();
    idle_inputs();
    wait_idle();
  endtask

  task automatic write_hilo(input logic [3:0] code, input logic [31:0] v);
    op = code; inA = v;
    step();
    idle_inputs();
  endtask

  initial begin
    logic [31:0] lo_snap, hi_snap;
    idle_inputs();
    reset = 1'b1;
    busy_cnt = 0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("out_none", out, 32'd0);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
    chk("mult_cycles", busy_cnt, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    op = OP_MFLO; #1;
    chk("mflo", out, 32'hFFFFFFF1);
    op = OP_MFHI; #1;
    chk("mfhi", out, 32'hFFFFFFFF);
    op = OP_NONE; #1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_cycles", busy_cnt, 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'd1);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    write_hilo(OP_MTHI, 32'h1234);
    chk("mthi", hi, 32'h1234);
    chk("mthi_lo_kept", lo, 32'h80000000);
    run_op(OP_DIVU, 32'd7, 32'd0);
    chk("div0_cycles", busy_cnt, 32'd10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h80000000);
    op = OP_MFHI; #1;
    chk("div0_mfhi", out, 32'h1234);
    op = OP_NONE; #1;

    // DIVU 100/7 with a start and an MTLO arriving during busy
    busy_cnt = 0;
    start = 1'b1; op = OP_DIVU; inA = 32'd100; inB = 32'd7;
    step();
    idle_inputs();
    step(); step();
    start = 1'b1; op = OP_MULT; inA = 32'd3; inB = 32'd3;
    step();
    start = 1'b0; op = OP_MTLO; inA = 32'hDEAD;
    step();
    idle_inputs();
    wait_idle();
    chk("divu_cycles", busy_cnt, 32'd10);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    step();
    chk("divu_no_restart", {31'd0, busy}, 32'd0);

    // Cancelled start and cancelled MTHI
    start = 1'b1; op = OP_MULT; inA = 32'd9; inB = 32'd9; cancel = 1'b1;
    step();
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    op = OP_MTHI; start = 1'b0; inA = 32'h5555;
    step();
    idle_inputs();
    chk("cancel_hi", hi, 32'd2);
    chk("cancel_lo", lo, 32'd14);

    // Start with a non-arithmetic op is ignored
    start = 1'b1; op = 4'hF; inA = 32'd1; inB = 32'd1;
    step();
    idle_inputs();
    chk("badop_busy", {31'd0, busy}, 32'd0);

    // Reset in the second busy cycle of a MULT aborts with no later write
    start = 1'b1; op = OP_MULT; inA = 32'd3; inB = 32'd4;
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("rstmid_late_lo", lo, 32'd0);

    // Reset wins over a simultaneous start
    write_hilo(OP_MTLO, 32'h77);
    start = 1'b1; op = OP_MULT; inA = 32'd2; inB = 32'd2; reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    chk("rstprio_busy", {31'd0, busy}, 32'd0);
    chk("rstprio_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL take parameter MULT_CYCLES, default 5, the number of busy cycles for mult/multu.
REQ-002 SHALL take parameter DIV_CYCLES, default 10, the number of busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin mult/multu/div/divu.
REQ-006 SHALL have port op  input  4  operation code, encoded per mdu_pkg.
REQ-007 SHALL have port inA  input  32  first operand, the rs value.
REQ-008 SHALL have port inB  input  32  second operand, the rt value.
REQ-009 SHALL have port cancel  input  1  exception or flush in the current cycle; suppresses start, mthi and mtlo.
REQ-010 SHALL have port busy  output  1  a multi-cycle operation is in progress.
REQ-011 SHALL have port hi  output  32  HI register.
REQ-012 SHALL have port lo  output  32  LO register.
REQ-013 SHALL have port out  output  32  combinational read data for mfhi/mflo.

Function
REQ-014 SHALL define ops: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO; any other code SHALL behave as NONE.
REQ-015 SHALL accept a start only if start=1, busy=0, cancel=0 and op is MULT, MULTU, DIV or DIVU; any other start SHALL be ignored with no state change.
REQ-016 On an accepted start, SHALL latch inA, inB and op, load the counter with MULT_CYCLES or DIV_CYCLES, and assert busy from the next cycle.
REQ-017 SHALL use a two-state FSM, IDLE and BUSY; busy=1 exactly while in BUSY.
REQ-018 In BUSY, SHALL decrement the counter each cycle; at the edge where the counter equals 1, SHALL write hi/lo, return to IDLE and deassert busy.
REQ-019 busy SHALL therefore be high for exactly N consecutive cycles; new hi/lo SHALL be visible in the first cycle with busy=0.
REQ-020 MULT SHALL form the 64-bit signed product; MULTU SHALL form the 64-bit unsigned product; hi=[63:32], lo=[31:0].
REQ-021 DIV SHALL give lo = signed quotient truncated toward zero and hi = remainder carrying the dividend's sign; DIVU SHALL give the unsigned quotient and remainder.
REQ-022 DIV or DIVU with inB=0 SHALL still run DIV_CYCLES with busy high, and SHALL leave hi/lo unchanged.
REQ-023 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 MTHI/MTLO SHALL write inA into hi/lo at the edge when busy=0 and cancel=0, take one cycle and never assert busy; while busy they SHALL be ignored.
REQ-025 out SHALL equal hi for MFHI, lo for MFLO, and 0 otherwise, independent of busy.
REQ-026 start, MTHI, MTLO, cancel and all operands arriving while in BUSY SHALL NOT alter the running operation; stalling the pipeline is the CPU's job.

Reset
REQ-027 With reset=1 at a clock edge, SHALL force IDLE, busy=0, hi=0, lo=0 and clear the counter and latched operands.
REQ-028 Reset during BUSY SHALL abort the operation with no hi/lo write; reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 SHALL place the op encodings and the FSM state type in shared package mdu_pkg, also used by the decoder.
REQ-030 SHALL be a single module, no sub-module; the product and quotient are computed from the latched operands and committed at the end of the count.

Verification
REQ-031 MULT inA=0xFFFFFFFD (-3), inB=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 MULTU inA=0xFFFFFFFF, inB=2 -> hi=0x00000001, lo=0xFFFFFFFE; DIV inA=0xFFFFFFF9 (-7), inB=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 MTHI 0x1234, then DIVU inA=7, inB=0 -> busy 10 cycles, hi=0x1234 and lo unchanged; MFHI -> out=0x1234.
REQ-034 Start DIVU 100/7, assert start MULT and MTLO in cycle 3 of busy -> both ignored; hi=2, lo=14 after 10 cycles.
REQ-035 start with cancel=1 -> busy stays 0, hi/lo unchanged; reset in cycle 2 of MULT -> busy=0, hi=lo=0 next cycle with no later write.
